complex_ratio_divider: RTL and testbench

- Downstream stage of the combine stage: consumes its registered 3Qp enumerator (real, imag) and denominator and produces the complex ratio r = (enum_real + j*enum_imag) / denum in 3Qp.
- Both quotients are computed with a shared-divisor iterative radix-2 restoring divider, one quotient bit per cycle.
- A valid/ready handshake sits on both sides so a later fit/compare stage can stall it.

---
 rtl/complex_ratio_divider_if.sv | 27 ++
 rtl/complex_ratio_divider.sv | 177 +++++++++++++++++
 tb/tb_complex_ratio_divider.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/complex_ratio_divider_if.sv
// Operand/result handshake bundle for complex_ratio_divider.
// Both sides carry signed 3Qp data with P fractional bits.
interface complex_ratio_divider_if #(
  parameter int unsigned P = 22
) ();
  logic signed [P+2:0] i_enum_real;
  logic signed [P+2:0] i_enum_imag;
  logic signed [P+2:0] i_denum;
  logic                i_valid;
  logic                o_ready;
  logic signed [P+2:0] o_r_real;
  logic signed [P+2:0] o_r_imag;
  logic                o_valid;
  logic                i_ready;
  logic                o_sat;
  logic                o_div_by_zero;

  modport slave (
    input  i_enum_real, i_enum_imag, i_denum, i_valid, i_ready,
    output o_ready, o_r_real, o_r_imag, o_valid, o_sat, o_div_by_zero
  );

  modport master (
    output i_enum_real, i_enum_imag, i_denum, i_valid, i_ready,
    input  o_ready, o_r_real, o_r_imag, o_valid, o_sat, o_div_by_zero
  );
endinterface

// File: rtl/complex_ratio_divider.sv
// Complex ratio (enum_real + j*enum_imag) / denum in 3Qp via a shared-divisor radix-2 restoring
// divider. Define DIV_ROUND_EN for round-half-away-from-zero (one extra guard iteration).
module complex_ratio_divider #(
  parameter int unsigned P = 22
) (
  input logic                   clk,
  input logic                   rst,
  complex_ratio_divider_if.slave bus
);
  localparam int unsigned W    = P + 3;
  localparam int unsigned RemW = P + 4;
`ifdef DIV_ROUND_EN
  localparam int unsigned QW   = P + 3;
`else
  localparam int unsigned QW   = P + 2;
`endif
  localparam int unsigned CntW = $clog2(QW);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e                   state_q, state_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [1:0][RemW-1:0]     rem_q, rem_d;
  logic [1:0][QW-1:0]       quo_q, quo_d;
  logic [1:0][1:0]          nlo_q, nlo_d;
  logic [1:0]               sign_q, sign_d;
  logic [1:0]               ovf_q, ovf_d;
  logic [W-1:0]             den_q, den_d;
  logic [1:0][W-1:0]        res_q, res_d;
  logic                     sat_q, sat_d;
  logic                     dbz_q, dbz_d;

  logic [1:0][W-1:0]        n_in, mag_in;
  logic [1:0]               ovf_in;
  logic                     dz_in;
  logic [1:0][RemW-1:0]     rem_sh, rem_nx;
  logic [1:0]               ge;
  logic [1:0][QW-1:0]       quo_nx;
  logic [1:0][W:0]          fr;

  // Returns {sat, value}: rounds (if enabled), clamps, saturates and applies the sign.
  function automatic logic [W:0] form_result(input logic [QW-1:0] qf, input logic neg,
                                             input logic ovf);
    logic [W-1:0] mag;
    logic [W-1:0] val;
    logic         sat;
    sat = ovf;
`ifdef DIV_ROUND_EN
    mag = {1'b0, qf[QW-1:1]} + {{(W-1){1'b0}}, qf[0]};
`else
    mag = {1'b0, qf};
`endif
    if (mag[W-1]) begin
      sat = 1'b1;
      mag = {1'b0, {(W-1){1'b1}}};
    end
    if (ovf) begin
      val = neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      val = neg ? (~mag + 1'b1) : mag;
    end
    return {sat, val};
  endfunction

  always_comb begin
    n_in[0] = bus.i_enum_real;
    n_in[1] = bus.i_enum_imag;
    dz_in   = bus.i_denum[W-1] | (bus.i_denum == '0);
    for (int c = 0; c < 2; c++) begin
      mag_in[c] = n_in[c][W-1] ? (~n_in[c] + 1'b1) : n_in[c];
      ovf_in[c] = {2'b00, mag_in[c]} >= {bus.i_denum, 2'b00};
      rem_sh[c] = {rem_q[c][RemW-2:0], nlo_q[c][1]};
      ge[c]     = rem_sh[c] >= {1'b0, den_q};
      rem_nx[c] = ge[c] ? (rem_sh[c] - {1'b0, den_q}) : rem_sh[c];
      quo_nx[c] = {quo_q[c][QW-2:0], ge[c]};
      fr[c]     = form_result(quo_nx[c], sign_q[c], ovf_q[c]);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    nlo_d   = nlo_q;
    sign_d  = sign_q;
    ovf_d   = ovf_q;
    den_d   = den_q;
    res_d   = res_q;
    sat_d   = sat_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      StIdle: begin
        if (bus.i_valid) begin
          if (dz_in) begin
            state_d = StDone;
            res_d   = '0;
            sat_d   = 1'b0;
            dbz_d   = 1'b1;
          end else begin
            state_d = StBusy;
            cnt_d   = CntW'(QW - 1);
            den_d   = bus.i_denum;
            quo_d   = '0;
            sat_d   = 1'b0;
            dbz_d   = 1'b0;
            for (int c = 0; c < 2; c++) begin
              sign_d[c] = n_in[c][W-1];
              ovf_d[c]  = ovf_in[c];
              // |N| < 4D, so the skipped upper iterations leave |N|>>2 as the remainder.
              rem_d[c]  = ovf_in[c] ? '0 : {3'b000, mag_in[c][W-1:2]};
              nlo_d[c]  = mag_in[c][1:0];
            end
          end
        end
      end
      StBusy: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        for (int c = 0; c < 2; c++) begin
          nlo_d[c] = {nlo_q[c][0], 1'b0};
        end
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == '0) begin
          state_d  = StDone;
          cnt_d    = '0;
          res_d[0] = fr[0][W-1:0];
          res_d[1] = fr[1][W-1:0];
          sat_d    = fr[0][W] | fr[1][W];
          dbz_d    = 1'b0;
        end
      end
      StDone: begin
        if (bus.i_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      nlo_q   <= '0;
      sign_q  <= '0;
      ovf_q   <= '0;
      den_q   <= '0;
      res_q   <= '0;
      sat_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      nlo_q   <= nlo_d;
      sign_q  <= sign_d;
      ovf_q   <= ovf_d;
      den_q   <= den_d;
      res_q   <= res_d;
      sat_q   <= sat_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.o_ready       = (state_q == StIdle);
  assign bus.o_valid       = (state_q == StDone);
  assign bus.o_r_real      = res_q[0];
  assign bus.o_r_imag      = res_q[1];
  assign bus.o_sat         = sat_q;
  assign bus.o_div_by_zero = dbz_q;
endmodule

// File: tb/tb_complex_ratio_divider.sv
// Directed self-checking bench for complex_ratio_divider (p = 22), with hand-computed
// expectations; follows DIV_ROUND_EN for latency and rounding.
module tb_complex_ratio_divider;
  localparam int unsigned P = 22;
  localparam int unsigned W = P + 3;
`ifdef DIV_ROUND_EN
  localparam int LAT = P + 3;
  localparam int EXP_THIRD2 = 2796203;
`else
  localparam int LAT = P + 2;
  localparam int EXP_THIRD2 = 2796202;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   lat;
  logic seen;

  complex_ratio_divider_if #(.P(P)) bus ();

  complex_ratio_divider #(.P(P)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one edge, then count edges until o_valid (bounded).
  task automatic run_job(input int nr, input int ni, input int d);
    bus.i_enum_real = nr[W-1:0];
    bus.i_enum_imag = ni[W-1:0];
    bus.i_denum     = d[W-1:0];
    bus.i_valid     = 1'b1;
    tick();
    bus.i_valid = 1'b0;
    lat = 0;
    while (!bus.o_valid && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  function automatic logic signed [63:0] s(input logic signed [W-1:0] v);
    return 64'(v);
  endfunction

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.i_enum_real = '0;
    bus.i_enum_imag = '0;
    bus.i_denum     = '0;
    bus.i_valid     = 1'b0;
    bus.i_ready     = 1'b1;
    tick();
    check("rst_ready", 64'(bus.o_ready), 1);
    check("rst_valid", 64'(bus.o_valid), 0);
    check("rst_real", s(bus.o_r_real), 0);
    check("rst_imag", s(bus.o_r_imag), 0);
    check("rst_flags", 64'({bus.o_sat, bus.o_div_by_zero}), 0);
    tick();
    rst = 1'b0;
    tick();

    // 1: 1.0 / 2.0
    run_job(4194304, 0, 8388608);
    check("t1_lat", lat, LAT);
    check("t1_real", s(bus.o_r_real), 2097152);
    check("t1_imag", s(bus.o_r_imag), 0);
    check("t1_flags", 64'({bus.o_sat, bus.o_div_by_zero}), 0);
    tick();
    check("t1_valid_1cyc", 64'(bus.o_valid), 0);
    check("t1_ready_back", 64'(bus.o_ready), 1);

    // 2: (-1.0 + j0.75) / 0.5
    run_job(-4194304, 3145728, 2097152);
    check("t2_real", s(bus.o_r_real), -8388608);
    check("t2_imag", s(bus.o_r_imag), 6291456);
    check("t2_sat", 64'(bus.o_sat), 0);
    tick();

    // 3: division by 3.0
    run_job(4194304, -4194304, 12582912);
    check("t3_real", s(bus.o_r_real), 1398101);
    check("t3_imag", s(bus.o_r_imag), -1398101);
    tick();
    run_job(8388608, 0, 12582912);
    check("t3b_real", s(bus.o_r_real), EXP_THIRD2);
    check("t3b_lat", lat, LAT);
    tick();

    // 4: saturation, then divide by zero and negative divisor
    run_job(12582912, -16777216, 2097152);
    check("t4_real", s(bus.o_r_real), 16777215);
    check("t4_imag", s(bus.o_r_imag), -16777216);
    check("t4_sat", 64'(bus.o_sat), 1);
    check("t4_dbz", 64'(bus.o_div_by_zero), 0);
    tick();
    run_job(4194304, 4194304, 0);
    check("t4z_lat", lat, 0);
    check("t4z_real", s(bus.o_r_real), 0);
    check("t4z_imag", s(bus.o_r_imag), 0);
    check("t4z_flags", 64'({bus.o_sat, bus.o_div_by_zero}), 1);
    tick();
    run_job(4194304, 0, -2097152);
    check("t4n_dbz", 64'(bus.o_div_by_zero), 1);
    tick();

    // 5: downstream stall with i_valid toggling
    bus.i_ready = 1'b0;
    run_job(-4194304, 3145728, 2097152);
    for (int k = 0; k < 10; k++) begin
      bus.i_valid     = k[0];
      bus.i_enum_real = W'(1000 * (k + 1));
      bus.i_enum_imag = W'(-2000 * (k + 1));
      bus.i_denum     = W'(4194304);
      tick();
      check("t5_hold_valid", 64'(bus.o_valid), 1);
      check("t5_hold_ready", 64'(bus.o_ready), 0);
      check("t5_hold_real", s(bus.o_r_real), -8388608);
      check("t5_hold_imag", s(bus.o_r_imag), 6291456);
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    tick();
    check("t5_rel_ready", 64'(bus.o_ready), 1);
    check("t5_rel_valid", 64'(bus.o_valid), 0);
    run_job(4194304, 4194304, 8388608);
    check("t5_next_real", s(bus.o_r_real), 2097152);
    check("t5_next_imag", s(bus.o_r_imag), 2097152);
    check("t5_next_lat", lat, LAT);
    tick();

    // 6: reset while busy (counter at 10 without rounding)
    bus.i_enum_real = W'(8388608);
    bus.i_enum_imag = W'(4194304);
    bus.i_denum     = W'(8388608);
    bus.i_valid     = 1'b1;
    tick();
    bus.i_valid = 1'b0;
    repeat (13) tick();
    check("t6_busy", 64'(bus.o_ready), 0);
    rst = 1'b1;
    #1;
    check("t6_rst_ready", 64'(bus.o_ready), 1);
    check("t6_rst_valid", 64'(bus.o_valid), 0);
    check("t6_rst_real", s(bus.o_r_real), 0);
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      seen = seen | bus.o_valid;
    end
    check("t6_no_valid", 64'(seen), 0);
    check("t6_idle_ready", 64'(bus.o_ready), 1);
    run_job(-4194304, 4194304, 12582912);
    check("t6_next_real", s(bus.o_r_real), -1398101);
    check("t6_next_imag", s(bus.o_r_imag), 1398101);
    check("t6_next_lat", lat, LAT);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
